// File: rtl/qspi_flash_pkg.sv
// Shared definitions for the QSPI NOR flash behavioural model.
// Contents: supported command opcodes, the continuous-read mode nibble,
// the protocol state enum and a JEDEC ID byte selector.
package qspi_flash_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_QUAD_READ = 8'hEB;
    localparam logic [7:0] CMD_READ_ID   = 8'h9F;

    localparam logic [3:0] CONT_MODE_NIBBLE = 4'hA;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_MODE,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_t;

    // Index 0 is the manufacturer byte; indices past 2 repeat the last byte.
    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        case (idx)
            2'd0:    return id[23:16];
            2'd1:    return id[15:8];
            default: return id[7:0];
        endcase
    endfunction

endpackage

// File: rtl/qspi_pin_sync.sv
// Two-flop synchroniser for the SPI pins plus registered sclk edge pulses.
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   cs, sclk     raw chip select / SPI clock pins
//   io[3:0]      raw {hold, wp, so, si} pin levels
//   cs_sync      synchronised chip select, aligned with rise/fall
//   io_sync      synchronised IO levels, aligned with rise/fall
//   rise, fall   one-clk pulses, 3 clk after the sclk pin edge
module qspi_pin_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       sclk,
    input  logic [3:0] io,
    output logic       cs_sync,
    output logic [3:0] io_sync,
    output logic       rise,
    output logic       fall
);

    logic       cs_meta, cs_stage;
    logic [3:0] io_meta, io_stage;
    logic [2:0] sclk_pipe;

    // The third cs/io stage keeps data and chip select in step with the
    // registered edge pulses, so the FSM sees all of them on the same clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_meta   <= 1'b1;
            cs_stage  <= 1'b1;
            cs_sync   <= 1'b1;
            io_meta   <= '0;
            io_stage  <= '0;
            io_sync   <= '0;
            sclk_pipe <= '0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, which is what builds the pipeline.
            cs_meta   <= cs;
            cs_stage  <= cs_meta;
            cs_sync   <= cs_stage;
            io_meta   <= io;
            io_stage  <= io_meta;
            io_sync   <= io_stage;
            sclk_pipe <= {sclk_pipe[1:0], sclk};
            rise      <= sclk_pipe[1] & ~sclk_pipe[2];
            fall      <= ~sclk_pipe[1] & sclk_pipe[2];
        end
    end

endmodule

// File: rtl/qspi_flash_model.sv
// Clocked behavioural model of a serial NOR flash (read side only).
// Oversamples the SPI pins on clk and serves 0x03, 0x0B, 0xEB and 0x9F.
// Ports:
//   clk, rst_n             system clock (>= 8x sclk), synchronous active-low reset
//   cs, sclk               chip select (active low), SPI clock (mode 0)
//   si, so, wp, hold       IO0..IO3, driven only while returning data
//   mem                    flat contents, byte n = mem[n*8 +: 8]
//   cmd_strobe             one-clk pulse when a command byte completes
//   last_cmd               last command byte received
//   cmd_unknown            one-clk pulse on an unsupported command
// Build option: define QSPI_FLASH_CONT_READ_EN to let the 0xEB mode byte
// enable continuous (XIP) reads; otherwise every transaction starts in CMD.
module qspi_flash_model
    import qspi_flash_pkg::*;
#(
    parameter int          MEM_BYTES  = 256,
    parameter int          ADDR_BYTES = 3,
    parameter int          QUAD_DUMMY = 4,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cs,
    input  logic                   sclk,
    inout  wire                    si,
    inout  wire                    so,
    inout  wire                    wp,
    inout  wire                    hold,
    input  logic [MEM_BYTES*8-1:0] mem,
    output logic                   cmd_strobe,
    output logic [7:0]             last_cmd,
    output logic                   cmd_unknown
);

    localparam int         AW               = $clog2(MEM_BYTES);
    localparam logic [5:0] ADDR_LAST_SINGLE = 6'(ADDR_BYTES * 8 - 1);
    localparam logic [5:0] ADDR_LAST_QUAD   = 6'(ADDR_BYTES * 2 - 1);
    localparam logic [5:0] DUMMY_LAST_FAST  = 6'd7;
    localparam logic [5:0] DUMMY_LAST_QUAD  = 6'(QUAD_DUMMY - 1);

    logic       cs_s, rise, fall;
    logic [3:0] io_s, io_pins;

    assign io_pins = {hold, wp, so, si};

    qspi_pin_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .cs      (cs),
        .sclk    (sclk),
        .io      (io_pins),
        .cs_sync (cs_s),
        .io_sync (io_s),
        .rise    (rise),
        .fall    (fall)
    );

    state_t      state, state_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [5:0]  cyc_cnt, cyc_cnt_n;
    logic [31:0] addr, addr_n;
    logic [7:0]  cmd_sr, cmd_sr_n, last_cmd_n;
    logic        quad, quad_n, fast, fast_n, id_mode, id_mode_n;
    logic        cont, cont_n, drive, drive_n, strobe_n, unknown_n;
    logic [3:0]  out_bits, out_bits_n;
    logic [7:0]  cur_byte;
`ifdef QSPI_FLASH_CONT_READ_EN
    logic [3:0]  mode_hi, mode_hi_n;
`endif

    always_comb begin
        // NOTE: every variable gets its default first, so no path leaves one unassigned and no latch is inferred.
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        cyc_cnt_n  = cyc_cnt;
        addr_n     = addr;
        cmd_sr_n   = cmd_sr;
        last_cmd_n = last_cmd;
        quad_n     = quad;
        fast_n     = fast;
        id_mode_n  = id_mode;
        cont_n     = cont;
        drive_n    = drive;
        out_bits_n = out_bits;
        strobe_n   = 1'b0;
        unknown_n  = 1'b0;
`ifdef QSPI_FLASH_CONT_READ_EN
        mode_hi_n  = mode_hi;
`endif
        cur_byte = id_mode ? id_byte(JEDEC_ID, addr[1:0]) : mem[{addr[AW-1:0], 3'b000} +: 8];

        // Deselect wins over a same-clk rise: partial state is discarded.
        if (cs_s) begin
            state_n   = cont ? ST_ADDR : ST_CMD;
            quad_n    = cont;
            fast_n    = 1'b0;
            id_mode_n = 1'b0;
            bit_cnt_n = '0;
            cyc_cnt_n = '0;
            addr_n    = '0;
            cmd_sr_n  = '0;
            drive_n   = 1'b0;
        end else begin
            case (state)
                ST_CMD: if (rise) begin
                    cmd_sr_n  = {cmd_sr[6:0], io_s[0]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        strobe_n   = 1'b1;
                        last_cmd_n = cmd_sr_n;
                        case (cmd_sr_n)
                            CMD_READ:      state_n = ST_ADDR;
                            CMD_FAST_READ: begin state_n = ST_ADDR; fast_n = 1'b1; end
                            CMD_QUAD_READ: begin state_n = ST_ADDR; quad_n = 1'b1; end
                            CMD_READ_ID:   begin state_n = ST_DATA; id_mode_n = 1'b1; end
                            default:       begin state_n = ST_IGNORE; unknown_n = 1'b1; end
                        endcase
                    end
                end
                ST_ADDR: if (rise) begin
                    // Shifting through a wider concat keeps the register a plain 32-bit shifter.
                    addr_n    = quad ? 32'({addr, io_s}) : 32'({addr, io_s[0]});
                    cyc_cnt_n = cyc_cnt + 6'd1;
                    if (cyc_cnt == (quad ? ADDR_LAST_QUAD : ADDR_LAST_SINGLE)) begin
                        cyc_cnt_n = '0;
                        if (quad)      state_n = ST_MODE;
                        else if (fast) state_n = ST_DUMMY;
                        else           state_n = ST_DATA;
                    end
                end
                ST_MODE: if (rise) begin
                    cyc_cnt_n = cyc_cnt + 6'd1;
`ifdef QSPI_FLASH_CONT_READ_EN
                    if (cyc_cnt == 6'd0) mode_hi_n = io_s;
`endif
                    if (cyc_cnt != 6'd0) begin
                        cyc_cnt_n = '0;
`ifdef QSPI_FLASH_CONT_READ_EN
                        cont_n = (mode_hi == CONT_MODE_NIBBLE);
`endif
                        state_n = (QUAD_DUMMY == 0) ? ST_DATA : ST_DUMMY;
                    end
                end
                ST_DUMMY: if (rise) begin
                    cyc_cnt_n = cyc_cnt + 6'd1;
                    if (cyc_cnt == (quad ? DUMMY_LAST_QUAD : DUMMY_LAST_FAST)) begin
                        cyc_cnt_n = '0;
                        state_n   = ST_DATA;
                    end
                end
                ST_DATA: if (fall) begin
                    drive_n = 1'b1;
                    if (quad) out_bits_n = (bit_cnt == 3'd0) ? cur_byte[7:4] : cur_byte[3:0];
                    else      out_bits_n = {2'b00, cur_byte[3'd7 - bit_cnt], 1'b0};
                    bit_cnt_n = bit_cnt + (quad ? 3'd4 : 3'd1);
                    if (bit_cnt == (quad ? 3'd4 : 3'd7)) begin
                        if (id_mode) addr_n = (addr[1:0] == 2'd2) ? addr : addr + 32'd1;
                        else         addr_n = 32'(addr[AW-1:0] + AW'(1));
                    end
                end
                default: ;  // ST_IGNORE waits for deselect
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_CMD;
            bit_cnt     <= '0;
            cyc_cnt     <= '0;
            addr        <= '0;
            cmd_sr      <= '0;
            last_cmd    <= 8'h00;
            quad        <= 1'b0;
            fast        <= 1'b0;
            id_mode     <= 1'b0;
            cont        <= 1'b0;
            drive       <= 1'b0;
            out_bits    <= '0;
            cmd_strobe  <= 1'b0;
            cmd_unknown <= 1'b0;
`ifdef QSPI_FLASH_CONT_READ_EN
            mode_hi     <= '0;
`endif
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            cyc_cnt     <= cyc_cnt_n;
            addr        <= addr_n;
            cmd_sr      <= cmd_sr_n;
            last_cmd    <= last_cmd_n;
            quad        <= quad_n;
            fast        <= fast_n;
            id_mode     <= id_mode_n;
            cont        <= cont_n;
            drive       <= drive_n;
            out_bits    <= out_bits_n;
            cmd_strobe  <= strobe_n;
            cmd_unknown <= unknown_n;
`ifdef QSPI_FLASH_CONT_READ_EN
            mode_hi     <= mode_hi_n;
`endif
        end
    end

    // cs_s gates the enables directly so pins release on the clk deselect is seen.
    assign si   = (drive && quad && !cs_s) ? out_bits[0] : 1'bz;
    assign so   = (drive && !cs_s)         ? out_bits[1] : 1'bz;
    assign wp   = (drive && quad && !cs_s) ? out_bits[2] : 1'bz;
    assign hold = (drive && quad && !cs_s) ? out_bits[3] : 1'bz;

endmodule
